// File: rtl/signed_binary_to_bcd_pkg.sv
// Shared types and constant helpers for the MeteoStation BCD formatters.
package meteo_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Never returns less than 1, so a counter sized with it always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) if ((64'd1 << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/signed_binary_to_bcd_if.sv
// Request/result bundle between sensor scaling logic and the BCD converter.
interface signed_binary_to_bcd_if #(
    parameter int INPUT_WIDTH    = 12,
    parameter int DECIMAL_DIGITS = 4
);
    import meteo_bcd_pkg::*;

    // i_Start is a request taken on a rising edge where o_Busy is low (i_Binary is sampled then);
    // o_DV is a one-cycle result strobe with no backpressure, o_BCD/o_Sign/o_Overflow hold until the next one.
    logic [INPUT_WIDTH-1:0]      i_Binary;
    logic                        i_Start;
    logic                        o_Busy;
    logic [DECIMAL_DIGITS*4-1:0] o_BCD;
    logic                        o_Sign;
    logic                        o_Overflow;
    logic                        o_DV;
    state_t                      o_State;

    modport master (
        output i_Binary, i_Start,
        input  o_Busy, o_BCD, o_Sign, o_Overflow, o_DV, o_State
    );

    modport slave (
        input  i_Binary, i_Start,
        output o_Busy, o_BCD, o_Sign, o_Overflow, o_DV, o_State
    );
endinterface

// File: rtl/signed_binary_to_bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit above 4, then shift one bit in at the bottom.
module bcd_dabble_step #(
    parameter int DIGITS = 5
) (
    input  logic [DIGITS*4-1:0] bcd,
    input  logic                shift_bit,
    output logic [DIGITS*4-1:0] bcd_next
);
    logic [DIGITS*4-1:0] adjusted;

    always_comb begin
        adjusted = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*4 +: 4] > 4'd4) adjusted[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    assign bcd_next = {adjusted[DIGITS*4-2:0], shift_bit};
endmodule

// File: rtl/signed_binary_to_bcd.sv
// Sign-magnitude BCD converter: latch |value|, run INPUT_WIDTH dabble steps, saturate on overflow.
module signed_binary_to_bcd
  import meteo_bcd_pkg::*;
#(
    parameter int INPUT_WIDTH    = 12,
    parameter int DECIMAL_DIGITS = 4,
    parameter bit SIGNED         = 1'b1
) (
    input  logic                   i_Clock,
    input  logic                   i_Rst_n,
    signed_binary_to_bcd_if.slave  bus
);
    localparam int          W          = INPUT_WIDTH;
    localparam int          D          = DECIMAL_DIGITS;
    localparam int          WD         = D + 1;
    localparam int          CNT_W      = clog2(W);
    localparam logic [63:0] OVF_LIMIT  = pow10(D);
    localparam logic [D*4-1:0] ALL_NINES = {D{4'h9}};

    state_t             state_q, state_d;
    logic [W-1:0]       mag_q;
    logic [WD*4-1:0]    bcd_q;
    logic [WD*4-1:0]    step_out;
    logic [CNT_W-1:0]   cnt_q;
    logic               sign_q, ovf_q;
    logic [D*4-1:0]     out_bcd_q;
    logic               out_sign_q, out_ovf_q, out_dv_q;

    logic               in_sign;
    logic [W-1:0]       in_mag;
    logic               in_ovf;

    assign in_sign = SIGNED ? bus.i_Binary[W-1] : 1'b0;
    assign in_mag  = in_sign ? (~bus.i_Binary + 1'b1) : bus.i_Binary;
    // Overflow is decided on the original magnitude since the guard digit cannot hold every width.
    assign in_ovf  = 64'(in_mag) >= OVF_LIMIT;

    bcd_dabble_step #(.DIGITS(WD)) u_step (
        .bcd       (bcd_q),
        .shift_bit (mag_q[W-1]),
        .bcd_next  (step_out)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.i_Start) state_d = CONVERT;
            CONVERT: if (cnt_q == CNT_W'(W - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            mag_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            ovf_q      <= 1'b0;
            out_bcd_q  <= '0;
            out_sign_q <= 1'b0;
            out_ovf_q  <= 1'b0;
            out_dv_q   <= 1'b0;
        end else begin
            out_dv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_Start) begin
                        mag_q  <= in_mag;
                        sign_q <= in_sign && (in_mag != '0);
                        ovf_q  <= in_ovf;
                        bcd_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                CONVERT: begin
                    bcd_q <= step_out;
                    mag_q <= {mag_q[W-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE: begin
                    out_dv_q   <= 1'b1;
                    out_sign_q <= sign_q;
                    out_ovf_q  <= ovf_q;
                    out_bcd_q  <= ovf_q ? ALL_NINES : bcd_q[D*4-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.o_Busy     = (state_q != IDLE);
    assign bus.o_BCD      = out_bcd_q;
    assign bus.o_Sign     = out_sign_q;
    assign bus.o_Overflow = out_ovf_q;
    assign bus.o_DV       = out_dv_q;
    assign bus.o_State    = state_q;
endmodule

// File: tb/tb_signed_binary_to_bcd.sv
// Scoreboard bench for signed_binary_to_bcd across three parameter sets.
module tb_signed_binary_to_bcd;
    import meteo_bcd_pkg::*;

    logic i_Clock = 1'b0;
    logic i_Rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 i_Clock = ~i_Clock;
    always @(posedge i_Clock) cyc <= cyc + 1;

    signed_binary_to_bcd_if #(.INPUT_WIDTH(12), .DECIMAL_DIGITS(4)) if0 ();
    signed_binary_to_bcd_if #(.INPUT_WIDTH(12), .DECIMAL_DIGITS(3)) if1 ();
    signed_binary_to_bcd_if #(.INPUT_WIDTH(8),  .DECIMAL_DIGITS(3)) if2 ();

    signed_binary_to_bcd #(.INPUT_WIDTH(12), .DECIMAL_DIGITS(4), .SIGNED(1'b1)) dut0 (
        .i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .bus(if0.slave));
    signed_binary_to_bcd #(.INPUT_WIDTH(12), .DECIMAL_DIGITS(3), .SIGNED(1'b1)) dut1 (
        .i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .bus(if1.slave));
    signed_binary_to_bcd #(.INPUT_WIDTH(8), .DECIMAL_DIGITS(3), .SIGNED(1'b0)) dut2 (
        .i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .bus(if2.slave));

    // Expected word layout: {overflow, sign, 10 BCD digits}
    logic [41:0] exp0_q[$];
    logic [41:0] exp1_q[$];
    logic [41:0] exp2_q[$];
    int          acc0_q[$];
    int          dv0_cnt = 0;
    logic        dv0_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [41:0] ref_model(input logic [31:0] val, input int w, input int d, input bit sgn);
        longint      mag, lim;
        logic [39:0] bcd;
        bit          neg, ovf;
        neg = sgn && val[w-1];
        mag = neg ? ((longint'(1) << w) - longint'(val)) : longint'(val);
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        ovf = (mag >= lim);
        if (mag == 0) neg = 1'b0;
        bcd = '0;
        for (int i = 0; i < d; i++) begin
            bcd[i*4 +: 4] = ovf ? 4'd9 : 4'(mag % 10);
            mag = mag / 10;
        end
        return {ovf, neg, bcd};
    endfunction

    always @(negedge i_Clock) begin
        logic [41:0] e;
        int          a;
        if (if0.o_DV) begin
            dv0_cnt++;
            check("dut0 dv width", 64'(dv0_prev), 64'd0);
            if (exp0_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut0 unexpected o_DV: got pulse, expected none (cycle %0d)", cyc);
            end else begin
                e = exp0_q.pop_front();
                a = acc0_q.pop_front();
                check("dut0 result", 64'({if0.o_Overflow, if0.o_Sign, 40'(if0.o_BCD)}), 64'(e));
                check("dut0 latency", 64'(cyc - a), 64'd13);
            end
        end
        dv0_prev = if0.o_DV;
    end

    always @(negedge i_Clock) begin
        logic [41:0] e;
        if (if1.o_DV) begin
            if (exp1_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut1 unexpected o_DV: got pulse, expected none (cycle %0d)", cyc);
            end else begin
                e = exp1_q.pop_front();
                check("dut1 result", 64'({if1.o_Overflow, if1.o_Sign, 40'(if1.o_BCD)}), 64'(e));
            end
        end
        if (if2.o_DV) begin
            if (exp2_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut2 unexpected o_DV: got pulse, expected none (cycle %0d)", cyc);
            end else begin
                e = exp2_q.pop_front();
                check("dut2 result", 64'({if2.o_Overflow, if2.o_Sign, 40'(if2.o_BCD)}), 64'(e));
            end
        end
    end

    // Called at a negedge; returns one negedge after raising i_Start.
    task automatic start0(input logic [11:0] v, input logic [41:0] e);
        int t = 0;
        while (if0.o_Busy && t < 100) begin @(negedge i_Clock); t++; end
        if (t >= 100) check("dut0 idle timeout", 64'(t), 64'd0);
        if0.i_Binary = v;
        if0.i_Start  = 1'b1;
        exp0_q.push_back(e);
        acc0_q.push_back(cyc + 1);
        @(negedge i_Clock);
        if0.i_Start = 1'b0;
    endtask

    task automatic start12(input logic [11:0] v, input logic [41:0] e1, input logic [41:0] e2);
        int t = 0;
        while ((if1.o_Busy || if2.o_Busy) && t < 100) begin @(negedge i_Clock); t++; end
        if (t >= 100) check("dut1/2 idle timeout", 64'(t), 64'd0);
        if1.i_Binary = v;
        if2.i_Binary = v[7:0];
        if1.i_Start  = 1'b1;
        if2.i_Start  = 1'b1;
        exp1_q.push_back(e1);
        exp2_q.push_back(e2);
        @(negedge i_Clock);
        if1.i_Start = 1'b0;
        if2.i_Start = 1'b0;
    endtask

    initial begin
        int          n, t;
        logic [11:0] v;
        if0.i_Binary = '0; if0.i_Start = 1'b0;
        if1.i_Binary = '0; if1.i_Start = 1'b0;
        if2.i_Binary = '0; if2.i_Start = 1'b0;

        repeat (3) @(negedge i_Clock);
        check("reset state", 64'(if0.o_State), 64'(IDLE));
        check("reset busy", 64'(if0.o_Busy), 64'd0);
        check("reset outputs", 64'({if0.o_DV, if0.o_Overflow, if0.o_Sign, if0.o_BCD}), 64'd0);
        i_Rst_n = 1'b1;
        @(negedge i_Clock);

        start0(12'h0F5, {2'b00, 40'h0245});
        start0(12'hFDB, {2'b01, 40'h0037});
        start0(12'h800, {2'b01, 40'h2048});
        start0(12'h7FF, {2'b00, 40'h2047});
        start0(12'h000, {2'b00, 40'h0000});
        start0(12'hFFF, {2'b01, 40'h0001});
        for (int i = 0; i < 40; i++) begin
            v = 12'($urandom_range(0, 4095));
            start0(v, ref_model(32'(v), 12, 4, 1'b1));
            repeat ($urandom_range(0, 3)) @(negedge i_Clock);
        end

        // Start while busy is dropped; start in the cycle after DONE is taken.
        t = 0;
        while (if0.o_Busy && t < 100) begin @(negedge i_Clock); t++; end
        repeat (2) @(negedge i_Clock);
        n = dv0_cnt;
        start0(12'h0F5, {2'b00, 40'h0245});
        repeat (4) @(negedge i_Clock);
        if0.i_Binary = 12'd99;
        if0.i_Start  = 1'b1;
        @(negedge i_Clock);
        if0.i_Start  = 1'b0;
        t = 0;
        while (!if0.o_DV && t < 50) begin @(negedge i_Clock); t++; end
        check("dut0 dv wait", 64'(t < 50), 64'd1);
        start0(12'h123, {2'b00, 40'h0291});
        repeat (5) @(negedge i_Clock);
        check("output hold", 64'({if0.o_Overflow, if0.o_Sign, if0.o_BCD}), 64'h0245);
        repeat (15) @(negedge i_Clock);
        check("dv count busy", 64'(dv0_cnt - n), 64'd2);

        // Asynchronous reset in the middle of a conversion.
        start0(12'h3E7, {2'b00, 40'h0999});
        repeat (5) @(negedge i_Clock);
        n = dv0_cnt;
        #2 i_Rst_n = 1'b0;
        #1;
        check("mid reset busy", 64'(if0.o_Busy), 64'd0);
        check("mid reset outputs", 64'({if0.o_DV, if0.o_Overflow, if0.o_Sign, if0.o_BCD}), 64'd0);
        exp0_q.delete();
        acc0_q.delete();
        repeat (2) @(negedge i_Clock);
        i_Rst_n = 1'b1;
        repeat (20) @(negedge i_Clock);
        check("dv after abort", 64'(dv0_cnt - n), 64'd0);
        start0(12'hE0C, {2'b01, 40'h0500});

        // Overflow (3 digits, signed) and unsigned 8-bit instances.
        start12(12'h5DC, {2'b10, 40'h999}, {2'b00, 40'h220});
        start12(12'hC19, {2'b01, 40'h999}, {2'b00, 40'h025});
        start12(12'h3E8, {2'b10, 40'h999}, {2'b00, 40'h232});
        start12(12'h0FF, {2'b00, 40'h255}, {2'b00, 40'h255});
        start12(12'h000, {2'b00, 40'h000}, {2'b00, 40'h000});
        for (int i = 0; i < 25; i++) begin
            v = 12'($urandom_range(0, 4095));
            start12(v, ref_model(32'(v), 12, 3, 1'b1), ref_model(32'(v[7:0]), 8, 3, 1'b0));
            repeat ($urandom_range(0, 2)) @(negedge i_Clock);
        end

        t = 0;
        while ((exp0_q.size() + exp1_q.size() + exp2_q.size()) != 0 && t < 200) begin
            @(negedge i_Clock); t++;
        end
        check("drain", 64'(exp0_q.size() + exp1_q.size() + exp2_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: got no finish, expected finish by 500000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/signed_binary_to_bcd.md
Name: signed_binary_to_bcd

Overview:
Parametrised signed binary-to-BCD converter for MeteoStation sensor readings such as temperature, pressure delta and humidity. It accepts a two's-complement or unsigned word and outputs a sign-magnitude BCD result with saturation and an overflow flag. It uses double-dabble with all digits adjusted in parallel, so latency is fixed at one cycle per input bit. It sits between the sensor scaling logic and the display/UART formatters.

Parameters:
INPUT_WIDTH, 12, width of i_Binary (valid range 2..32).
DECIMAL_DIGITS, 4, number of BCD digits in o_BCD (valid range 1..10).
SIGNED, 1, 1 = i_Binary is two's complement; 0 = i_Binary is unsigned.

Ports:
i_Clock  in  1  system clock, rising edge.
i_Rst_n  in  1  reset, asynchronous assert, active-low.
i_Binary  in  INPUT_WIDTH  value to convert; sampled only when the start is accepted.
i_Start  in  1  conversion request; accepted only when o_Busy=0.
o_Busy  out  1  high whenever the FSM is not in IDLE.
o_BCD  out  DECIMAL_DIGITS*4  magnitude in BCD, digit 0 in bits [3:0].
o_Sign  out  1  1 = negative result.
o_Overflow  out  1  1 = magnitude exceeded 10^DECIMAL_DIGITS-1; o_BCD is then saturated.
o_DV  out  1  single-cycle pulse marking a new result.

Behaviour:
- Clock and reset: one clock, i_Clock. Reset i_Rst_n is asynchronous and active-low.
- Reset values: FSM=IDLE, o_Busy=0, o_BCD=0, o_Sign=0, o_Overflow=0, o_DV=0, all internal registers 0.
- Reset mid-conversion: the conversion is aborted, no o_DV is produced, and outputs return to 0.
- States:
  - IDLE: wait for a start.
  - CONVERT: runs for exactly INPUT_WIDTH cycles.
  - DONE: lasts 1 cycle, then returns to IDLE.
- Start acceptance: in IDLE with i_Start=1, the block latches the sign and the magnitude and goes to CONVERT.
- Sign and magnitude:
  - sign = SIGNED ? i_Binary[MSB] : 0.
  - The magnitude register is INPUT_WIDTH bits wide and holds the absolute value computed modulo 2^INPUT_WIDTH.
  - The most-negative input (e.g. 12'h800) therefore yields magnitude 2048, which is correct as an unsigned value.
- CONVERT step (one combinational step per cycle):
  - Every BCD digit >4 gets +3, all digits in parallel.
  - The BCD+magnitude concatenation then shifts left by 1, with the magnitude MSB entering BCD bit 0.
- Loop counter: counts 0..INPUT_WIDTH-1. At the terminal count the FSM goes to DONE.
- Working BCD register: DECIMAL_DIGITS+1 digits internally, so values up to the 4-digit guard cannot alias.
- DONE update: o_BCD, o_Sign, o_Overflow and o_DV=1 are all registered together in this cycle.
  - Overflow condition: original magnitude >= 10^DECIMAL_DIGITS. The comparison uses a localparam constant; the result is o_Overflow=1 and o_BCD = all digits 9.
  - Otherwise: o_Overflow=0 and o_BCD = the low DECIMAL_DIGITS digits.
  - Zero magnitude forces o_Sign=0, so no negative zero is ever produced.
- Latency: if the start is sampled at edge N, o_DV is high in the cycle after edge N+INPUT_WIDTH+1, i.e. INPUT_WIDTH+1 cycles after acceptance.
- Back-to-back: the next start can be accepted in the cycle after DONE, giving a throughput of one result per INPUT_WIDTH+2 cycles.
- Ignored starts: i_Start while o_Busy=1 (CONVERT or DONE) is ignored, not queued, and i_Binary changes are ignored in those states.
- Output hold: o_BCD, o_Sign and o_Overflow hold their last result until the next DONE, and stay stable through IDLE and CONVERT.
- Illegal state encoding: the FSM goes to IDLE without a DV.

Decomposition:
- Shared package meteo_bcd_pkg contains:
  - the FSM state encoding (IDLE, CONVERT, DONE);
  - a constant function pow10(n) returning 10^n;
  - a constant function clog2 for sizing the loop counter.
- Sub-module bcd_dabble_step: combinational, parametrised by digit count. It performs the parallel add-3 on every digit >4 followed by the 1-bit shift-in. It is instantiated once and is reusable by the future multi-channel formatter.

Test Plan:
- SIGNED=1, W=12, D=4; i_Binary=12'h0F5 (245) -> o_BCD=16'h0245, Sign=0, Ovf=0; o_DV pulses exactly 13 cycles after acceptance and is 1 cycle wide.
- i_Binary=12'hFDB (-37) -> o_BCD=16'h0037, Sign=1. Then i_Binary=12'h800 (-2048) -> o_BCD=16'h2048, Sign=1, Ovf=0.
- W=12, D=3, SIGNED=1; i_Binary=12'h5DC (1500) -> o_BCD=12'h999, Ovf=1, Sign=0. Then i_Binary=12'hC19 (-999) -> o_BCD=12'h999, Ovf=0, Sign=1.
- SIGNED=0, W=8, D=3; i_Binary=8'hFF -> o_BCD=12'h255, Sign=0. i_Binary=0 -> o_BCD=0, Sign=0, DV still pulses.
- Start while busy: start 245, pulse i_Start with value 99 at cycle 5 -> exactly one DV, result 0245. A start in the cycle after DONE is accepted.
- Reset mid-conversion: drop i_Rst_n at cycle 6 -> all outputs are 0 asynchronously and no DV appears. After release, a new start converts correctly.
